// File: rtl/sha256_core.sv
// sha256_core: iterative SHA-256/SHA-224 compression core, one round per clock
module sha256_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);
    typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

    localparam logic [0:7][31:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [0:7][31:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t            state, state_nx;
    logic [0:7][31:0]  hs;
    logic [0:7][31:0]  v;
    logic [0:15][31:0] w;
    logic [5:0]        t;
    logic [31:0]       t1, t2, w_new;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign ready  = (state == IDLE);
    assign digest = hs;

    // round function and next schedule word; w[0] is always W_t
    always_comb begin
        t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[0];
        t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_new = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next state; DONE spends t=0 on the feed-forward add and t=1 on the return to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (init || next) ? ROUNDS : IDLE;
            ROUNDS:  state_nx = (t == 6'd63) ? DONE : ROUNDS;
            DONE:    state_nx = (t == 6'd1) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: block latch, rounds, hash update and valid flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs           <= '0;
            v            <= '0;
            w            <= '0;
            t            <= '0;
            digest_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (init || next) begin
                    if (init) hs <= mode ? IV256 : IV224;
                    v            <= init ? (mode ? IV256 : IV224) : hs;
                    w            <= block;
                    t            <= '0;
                    digest_valid <= 1'b0;
                end
                ROUNDS: begin
                    v <= {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
                    w <= {w[1:15], w_new};
                    t <= t + 6'd1;
                end
                DONE: if (t == 6'd0) begin
                    for (int i = 0; i < 8; i++) hs[i] <= hs[i] + v[i];
                    t <= 6'd1;
                end else begin
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_core.sv
// tb_sha256_core: directed scoreboard bench for sha256_core
module tb_sha256_core;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init = 1'b0;
    logic         next = 1'b0;
    logic         mode = 1'b1;
    logic [511:0] block = '0;
    logic         ready, digest_valid;
    logic [255:0] digest;

    typedef struct {
        logic [255:0] exp;
        logic [255:0] mask;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    localparam logic [511:0]  ABC    = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0]  ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0]  ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [255:0]  M256   = {256{1'b1}};
    localparam logic [255:0]  M224   = {{224{1'b1}}, 32'h0};
    localparam logic [511:0]  GEN1   = {32'h01000000, 256'h0,
        224'h3BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA};
    localparam logic [511:0]  GEN2   = {128'h4B1E5E4A29AB5F49FFFF001D1DAC2B7C, 32'h80000000, 320'h0, 32'h00000280};
    localparam logic [255:0]  GENH   = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    always #5 clk = ~clk;

    sha256_core dut (
        .clk(clk), .reset_n(reset_n), .init(init), .next(next), .mode(mode),
        .block(block), .ready(ready), .digest(digest), .digest_valid(digest_valid)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_digest(input logic [255:0] e, input logic [255:0] m);
        exp_t x;
        x.exp  = e;
        x.mask = m;
        sb.push_back(x);
    endtask

    // called at a negedge; drives the request for exactly one rising edge
    task automatic start(input bit i, input bit nx, input bit m, input logic [511:0] b);
        init  = i;
        next  = nx;
        mode  = m;
        block = b;
        @(negedge clk);
        init = 1'b0;
        next = 1'b0;
    endtask

    // counts edges after the accepting edge until ready, optionally poking the busy core
    task automatic wait_done(input string tag, input bit disturb);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_dv_clr"}, 256'(digest_valid), 256'(0));
            if (disturb && n == 5) begin
                init  = 1'b1;
                next  = 1'b1;
                block = {16{$urandom}};
                mode  = ~mode;
            end
            if (disturb && n == 6) begin
                init = 1'b0;
                next = 1'b0;
            end
        end while (!ready && n < 200);
        check({tag, "_latency"}, 256'(n), 256'(66));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_dv"}, 256'(digest_valid), 256'(1));
            check(tag, digest & e.mask, e.exp & e.mask);
        end
    endtask

    initial begin
        logic [255:0] hh;
        repeat (2) @(negedge clk);
        check("rst_ready", 256'(ready), 256'(1));
        check("rst_dv", 256'(digest_valid), 256'(0));
        check("rst_digest", digest, 256'h0);
        reset_n = 1'b1;
        @(negedge clk);

        expect_digest(ABC256, M256);
        start(1, 0, 1, ABC);
        wait_done("abc256", 0);
        repeat (5) @(negedge clk);
        check("hold_dv", 256'(digest_valid), 256'(1));
        check("hold_digest", digest, ABC256);

        expect_digest(ABC224, M224);
        start(1, 0, 0, ABC);
        wait_done("abc224", 0);

        expect_digest(ABC256, M256);
        start(1, 0, 1, ABC);
        wait_done("busy", 1);

        expect_digest(ABC256, M256);
        start(1, 1, 1, ABC);
        wait_done("prio", 0);

        start(1, 0, 1, GEN1);
        wait_done("gen1", 0);
        start(0, 1, 1, GEN2);
        wait_done("gen2", 0);
        hh = digest;
        expect_digest(GENH, M256);
        start(1, 0, 1, {hh, 32'h80000000, 192'h0, 32'h00000100});
        wait_done("genesis", 0);

        start(1, 0, 1, ABC);
        repeat (29) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 256'(ready), 256'(1));
        check("mid_rst_dv", 256'(digest_valid), 256'(0));
        check("mid_rst_digest", digest, 256'h0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_digest(ABC256, M256);
        start(1, 0, 1, ABC);
        wait_done("post_rst", 0);

        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
